// File: rtl/mib_slave.sv
// mib_slave: downstream end of the MIB command bus.
// Decodes the start / rd_wr_n / addr_data / slave_ack protocol from the MIB
// master. Each transaction becomes one request on the local 32-bit register
// port. The slave answers with slave_ack, and for reads it also returns data
// on the shared tri-state bus.
//
// Ports:
//   clk, rst_n           clock and asynchronous active-low reset
//   start, rd_wr_n       first-word strobe and direction (1 = read) from master
//   addr_data            16-bit multiplexed address/data bus (tri-state)
//   slave_ack            one-cycle completion pulse
//   reg_req, reg_wr      local request (held until ack/timeout) and direction
//   reg_addr, reg_wdata  local address and write data
//   reg_rdata, reg_ack   local read data and acceptance
//   timeout_err          one-cycle pulse when a local request times out
module mib_slave #(
    parameter int unsigned ADDR_BITS          = 24,
    parameter int unsigned DATA_BITS          = 32,
    parameter int unsigned LOCAL_TIMEOUT_CLKS = 24
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 rd_wr_n,
    inout  wire logic [15:0]     addr_data,
    output logic                 slave_ack,
    output logic                 reg_req,
    output logic                 reg_wr,
    output logic [ADDR_BITS-1:0] reg_addr,
    output logic [DATA_BITS-1:0] reg_wdata,
    input  logic [DATA_BITS-1:0] reg_rdata,
    input  logic                 reg_ack,
    output logic                 timeout_err
);

    localparam int unsigned CNT_W = 5;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ADDR_LO  = 3'd1,
        WDATA_HI = 3'd2,
        WDATA_LO = 3'd3,
        REQ      = 3'd4,
        ACK      = 3'd5,
        RD_LO    = 3'd6
    } state_t;

    state_t               state, state_nxt;
    logic                 is_read, is_read_nxt;
    logic [CNT_W-1:0]     count, count_nxt;
    logic                 addr_data_oe, addr_data_oe_nxt;
    logic [15:0]          bus_word, bus_word_nxt;
    logic [15:0]          rdata_lo, rdata_lo_nxt;
    logic                 slave_ack_nxt, reg_req_nxt, reg_wr_nxt, timeout_err_nxt;
    logic [ADDR_BITS-1:0] reg_addr_nxt;
    logic [DATA_BITS-1:0] reg_wdata_nxt;
    logic                 timeout_hit;

    // The slave drives the bus only while returning read words.
    assign addr_data = addr_data_oe ? bus_word : 'z;

    // The last counted cycle of an unacknowledged request.
    assign timeout_hit = (count == CNT_W'(LOCAL_TIMEOUT_CLKS - 1));

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            is_read      <= 1'b0;
            count        <= '0;
            addr_data_oe <= 1'b0;
            bus_word     <= '0;
            rdata_lo     <= '0;
            slave_ack    <= 1'b0;
            reg_req      <= 1'b0;
            reg_wr       <= 1'b0;
            reg_addr     <= '0;
            reg_wdata    <= '0;
            timeout_err  <= 1'b0;
        end else begin
            state        <= state_nxt;
            is_read      <= is_read_nxt;
            count        <= count_nxt;
            addr_data_oe <= addr_data_oe_nxt;
            bus_word     <= bus_word_nxt;
            rdata_lo     <= rdata_lo_nxt;
            slave_ack    <= slave_ack_nxt;
            reg_req      <= reg_req_nxt;
            reg_wr       <= reg_wr_nxt;
            reg_addr     <= reg_addr_nxt;
            reg_wdata    <= reg_wdata_nxt;
            timeout_err  <= timeout_err_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:     if (start) state_nxt = ADDR_LO;
            ADDR_LO:  state_nxt = is_read ? REQ : WDATA_HI;
            WDATA_HI: state_nxt = WDATA_LO;
            WDATA_LO: state_nxt = REQ;
            REQ: begin
                if (reg_ack)          state_nxt = ACK;
                else if (timeout_hit) state_nxt = IDLE;
            end
            ACK:      state_nxt = is_read ? RD_LO : IDLE;
            RD_LO:    state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Next values of the registered outputs and datapath.
    always_comb begin
        is_read_nxt      = is_read;
        count_nxt        = count;
        addr_data_oe_nxt = addr_data_oe;
        bus_word_nxt     = bus_word;
        rdata_lo_nxt     = rdata_lo;
        reg_addr_nxt     = reg_addr;
        reg_wdata_nxt    = reg_wdata;
        slave_ack_nxt    = 1'b0;
        timeout_err_nxt  = 1'b0;
        // reg_req is high exactly while the FSM sits in REQ.
        reg_req_nxt      = (state_nxt == REQ);
        reg_wr_nxt       = (state_nxt == REQ) && !is_read;

        unique case (state)
            IDLE: begin
                if (start) begin
                    // High address bits above ADDR_BITS are dropped.
                    reg_addr_nxt[ADDR_BITS-1:16] = addr_data[ADDR_BITS-17:0];
                    is_read_nxt                  = rd_wr_n;
                end
            end
            ADDR_LO: begin
                reg_addr_nxt[15:0] = addr_data;
                count_nxt          = '0;
                reg_wr_nxt         = 1'b0;
                reg_req_nxt        = is_read;
            end
            WDATA_HI: reg_wdata_nxt[31:16] = addr_data;
            WDATA_LO: begin
                reg_wdata_nxt[15:0] = addr_data;
                count_nxt           = '0;
                reg_wr_nxt          = 1'b1;
            end
            REQ: begin
                if (reg_ack) begin
                    slave_ack_nxt    = 1'b1;
                    addr_data_oe_nxt = is_read;
                    bus_word_nxt     = reg_rdata[31:16];
                    rdata_lo_nxt     = reg_rdata[15:0];
                end else if (timeout_hit) begin
                    timeout_err_nxt = 1'b1;
                end else begin
                    count_nxt = count + CNT_W'(1);
                end
            end
            ACK:     bus_word_nxt     = rdata_lo;
            RD_LO:   addr_data_oe_nxt = 1'b0;
            default: addr_data_oe_nxt = 1'b0;
        endcase
    end

endmodule
